// File: rtl/spi_accel_pkg.sv
// -----------------------------------------------------------------------------
// spi_accel_pkg
// Shared constants and types for the SPI accelerometer target:
//   - instruction opcodes (register write / register read)
//   - register map addresses (device id, X/Y/Z samples, setup bank)
//   - protocol FSM state encoding
//   - helper that decides whether an address falls inside the setup bank
// -----------------------------------------------------------------------------
package spi_accel_pkg;

    // Instruction opcodes
    localparam logic [7:0] REG_WRITE   = 8'h0A;
    localparam logic [7:0] REG_READ    = 8'h0B;

    // Register map
    localparam logic [7:0] ADDR_DEVID  = 8'h00;
    localparam logic [7:0] ADDR_XDATA  = 8'h09;
    localparam logic [7:0] ADDR_YDATA  = 8'h0A;
    localparam logic [7:0] ADDR_ZDATA  = 8'h0B;
    localparam logic [7:0] SETUP_FIRST = 8'h20;
    localparam logic [7:0] SETUP_LAST  = 8'h2D;
    localparam logic [7:0] POWER_CTL   = 8'h2D;

    // Number of registers in the setup bank (0x20..0x2D)
    localparam int SETUP_COUNT = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WDATA  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } fsm_state_e;

    // True when the address lands inside the writable setup bank
    function automatic logic is_setup_addr(input logic [7:0] addr);
        return (addr >= SETUP_FIRST) && (addr <= SETUP_LAST);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// -----------------------------------------------------------------------------
// spi_input_sync
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a
// rise/fall detector built from the synchronized value and a one-cycle
// delayed copy.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset (chain loads RESET_VAL)
//   din   - raw asynchronous input pin
//   sync  - synchronized level
//   rise  - one-cycle pulse on synchronized 0->1
//   fall  - one-cycle pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              prev_q;
    logic              prev_d;

    // Next-state for the shift chain and the delayed copy
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
        prev_d  = chain_q[STAGES-1];
    end

    // Synchronizer and edge-history flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync = chain_q[STAGES-1];
    assign rise = chain_q[STAGES-1] & ~prev_q;
    assign fall = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_accel_target.sv
// -----------------------------------------------------------------------------
// spi_accel_target
// SPI mode-0 target emulating the accelerometer end of the SPI link.
// Transactions are: instruction byte (0x0A write / 0x0B read), address byte,
// then any number of data bytes. Writes land in the setup bank 0x20..0x2D;
// reads serve DEVID, X/Y/Z snapshots and the setup bank.
//
// Build option: define SPI_ACCEL_TARGET_AUTOINC_EN to make the address step
// after every completed data byte (burst walks registers). Without it the
// address stays fixed and every reloaded read byte re-snapshots X/Y/Z, giving
// a stream of fresh samples from one register.
//
// Ports:
//   CLK        - system clock (125 MHz)
//   RESET      - asynchronous active-high reset
//   CS         - chip select, active low (asynchronous to CLK)
//   SCLK       - SPI clock, idles low, at most CLK/8
//   MOSI       - serial data in, MSB first
//   MISO       - serial data out, MSB first, 0 when not reading
//   X/Y/Z_DATA - live sample inputs
//   WR_STROBE  - one-cycle pulse per completed write data byte
//   WR_ADDR    - address of the last completed write byte
//   WR_DATA    - data of the last completed write byte
//   MEASURE_EN - bit 1 of register 0x2D
//   BUSY       - synchronized chip select is active
// -----------------------------------------------------------------------------
module spi_accel_target
    import spi_accel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hAD
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] X_DATA,
    input  logic [7:0] Y_DATA,
    input  logic [7:0] Z_DATA,
    output logic       WR_STROBE,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       MEASURE_EN,
    output logic       BUSY
);

    // Synchronized pins and edge pulses
    logic cs_sync_s,   cs_rise_s,   cs_fall_s;
    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic mosi_sync_s, mosi_rise_s, mosi_fall_s;
    logic sync_unused_s;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(CLK), .rst(RESET), .din(CS),
        .sync(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(CLK), .rst(RESET), .din(SCLK),
        .sync(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(CLK), .rst(RESET), .din(MOSI),
        .sync(mosi_sync_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
    );

    // Only the levels/pulses the protocol needs are consumed
    assign sync_unused_s = ^{sclk_sync_s, mosi_rise_s, mosi_fall_s};

    // State
    fsm_state_e state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_in_q,  shift_in_d;
    logic       wr_mode_q,   wr_mode_d;
    logic [7:0] addr_q,      addr_d;
    logic [7:0] rd_shift_q,  rd_shift_d;
    logic       miso_q,      miso_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic [7:0] snap_x_q,    snap_x_d;
    logic [7:0] snap_y_q,    snap_y_d;
    logic [7:0] snap_z_q,    snap_z_d;
    logic [7:0] bank_q [SETUP_COUNT];
    logic [7:0] bank_d [SETUP_COUNT];

    logic [7:0] rx_byte_s;
    logic       byte_done_s;
    logic [7:0] next_addr_s;

    // Byte as it will look once the current rise's MOSI bit is shifted in
    assign rx_byte_s   = {shift_in_q[6:0], mosi_sync_s};
    assign byte_done_s = sclk_rise_s && (bit_cnt_q == 3'd0);

`ifdef SPI_ACCEL_TARGET_AUTOINC_EN
    assign next_addr_s = addr_q + 8'd1;
`else
    assign next_addr_s = addr_q;
`endif

    // Register-map read decode; setup bank index is the low nibble
    function automatic logic [7:0] read_mux(input logic [7:0] a,
                                            input logic [7:0] x,
                                            input logic [7:0] y,
                                            input logic [7:0] z);
        logic [7:0] r;
        case (a)
            ADDR_DEVID: r = DEVID;
            ADDR_XDATA: r = x;
            ADDR_YDATA: r = y;
            ADDR_ZDATA: r = z;
            default: begin
                if (is_setup_addr(a)) begin
                    r = bank_q[a[3:0]];
                end else begin
                    r = 8'h00;
                end
            end
        endcase
        return r;
    endfunction

    // Protocol FSM next-state and datapath
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        wr_mode_d   = wr_mode_q;
        addr_d      = addr_q;
        rd_shift_d  = rd_shift_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_z_d    = snap_z_q;
        bank_d      = bank_q;

        // CS high (including the cycle it rises) aborts everything and
        // swallows any SCLK edge seen in the same cycle
        if (cs_sync_s || cs_rise_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd7;
            miso_d    = 1'b0;
        end else begin
            if ((state_q != ST_IDLE) && sclk_rise_s) begin
                shift_in_d = rx_byte_s;
                bit_cnt_d  = bit_cnt_q - 3'd1;
            end else begin
                shift_in_d = shift_in_q;
            end

            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall_s) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 3'd7;
                        snap_x_d  = X_DATA;
                        snap_y_d  = Y_DATA;
                        snap_z_d  = Z_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    miso_d = 1'b0;
                    if (byte_done_s) begin
                        if (rx_byte_s == REG_WRITE) begin
                            state_d   = ST_ADDR;
                            wr_mode_d = 1'b1;
                        end else if (rx_byte_s == REG_READ) begin
                            state_d   = ST_ADDR;
                            wr_mode_d = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    miso_d = 1'b0;
                    if (byte_done_s) begin
                        addr_d = rx_byte_s;
                        if (wr_mode_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d    = ST_RDATA;
                            rd_shift_d = read_mux(rx_byte_s, snap_x_q, snap_y_q, snap_z_q);
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_WDATA: begin
                    miso_d = 1'b0;
                    if (byte_done_s) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = rx_byte_s;
                        addr_d      = next_addr_s;
                        if (is_setup_addr(addr_q)) begin
                            bank_d[addr_q[3:0]] = rx_byte_s;
                        end else begin
                            bank_d = bank_q;
                        end
                    end else begin
                        wr_strobe_d = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall_s) begin
                        miso_d     = rd_shift_q[7];
                        rd_shift_d = {rd_shift_q[6:0], 1'b0};
                    end else if (byte_done_s) begin
                        addr_d = next_addr_s;
`ifdef SPI_ACCEL_TARGET_AUTOINC_EN
                        rd_shift_d = read_mux(next_addr_s, snap_x_q, snap_y_q, snap_z_q);
`else
                        // Fixed address: take a fresh sample for each byte
                        snap_x_d   = X_DATA;
                        snap_y_d   = Y_DATA;
                        snap_z_d   = Z_DATA;
                        rd_shift_d = read_mux(addr_q, X_DATA, Y_DATA, Z_DATA);
`endif
                    end else begin
                        rd_shift_d = rd_shift_q;
                    end
                end
                ST_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // All protocol state, output and bank flops
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd7;
            shift_in_q  <= 8'h00;
            wr_mode_q   <= 1'b0;
            addr_q      <= 8'h00;
            rd_shift_q  <= 8'h00;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            snap_x_q    <= 8'h00;
            snap_y_q    <= 8'h00;
            snap_z_q    <= 8'h00;
            for (int i = 0; i < SETUP_COUNT; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            wr_mode_q   <= wr_mode_d;
            addr_q      <= addr_d;
            rd_shift_q  <= rd_shift_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_z_q    <= snap_z_d;
            for (int i = 0; i < SETUP_COUNT; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign MISO       = miso_q;
    assign WR_STROBE  = wr_strobe_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign MEASURE_EN = bank_q[POWER_CTL[3:0]][1];
    assign BUSY       = ~cs_sync_s;

endmodule

// File: tb/tb_spi_accel_target.sv
// -----------------------------------------------------------------------------
// tb_spi_accel_target
// Directed bench for spi_accel_target. Expected read bytes and write strobes
// are queued when the stimulus is issued and compared as the DUT produces
// them. Honors SPI_ACCEL_TARGET_AUTOINC_EN for burst expectations.
// -----------------------------------------------------------------------------
module tb_spi_accel_target;

    localparam int H = 8;   // CLK cycles per SCLK half period (SCLK = CLK/16)

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic [7:0] X_DATA;
    logic [7:0] Y_DATA;
    logic [7:0] Z_DATA;
    logic       WR_STROBE;
    logic [7:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       MEASURE_EN;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_rd_q [$];
    logic [15:0] exp_wr_q [$];
    logic [15:0] obs_wr_q [$];

    spi_accel_target #(.SYNC_STAGES(2), .DEVID(8'hAD)) dut (
        .CLK(CLK), .RESET(RESET), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA),
        .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .MEASURE_EN(MEASURE_EN), .BUSY(BUSY)
    );

    always #4 CLK = ~CLK;

    // Record every cycle WR_STROBE is high; a stretched pulse shows as extra entries
    always @(negedge CLK) begin
        if (WR_STROBE === 1'b1) obs_wr_q.push_back({WR_ADDR, WR_DATA});
    end

    // Global time limit
    initial begin
        #(3000000);
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = tx[i];
            wait_clk(H);
            rx[i] = MISO;
            SCLK = 1'b1;
            wait_clk(H);
            SCLK = 1'b0;
        end
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_end();
        MOSI = 1'b0;
        wait_clk(H);
        CS = 1'b1;
        wait_clk(2 * H);
    endtask

    // Read n bytes from addr; each byte is checked against the queued expectation
    task automatic spi_read(input string tag, input logic [7:0] addr, input int n);
        logic [7:0] rx;
        logic [7:0] exp;
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(addr, 8, rx);
        for (int k = 0; k < n; k++) begin
            spi_bits(8'h00, 8, rx);
            if (exp_rd_q.size() > 0) begin
                exp = exp_rd_q.pop_front();
                check($sformatf("%s_b%0d", tag, k), {8'h00, rx}, {8'h00, exp});
            end else begin
                check($sformatf("%s_noexp%0d", tag, k), 16'd1, 16'd0);
            end
        end
        cs_end();
    endtask

    // Write n bytes (data[15:8] first) starting at addr
    task automatic spi_write(input logic [7:0] addr, input logic [15:0] data, input int n);
        logic [7:0] rx;
        cs_begin();
        spi_bits(8'h0A, 8, rx);
        spi_bits(addr, 8, rx);
        for (int k = 0; k < n; k++) begin
            spi_bits(data[15 - 8*k -: 8], 8, rx);
        end
        cs_end();
    endtask

    // Compare recorded strobes against expected strobes, then clear both
    task automatic check_writes(input string tag);
        logic [15:0] e;
        logic [15:0] o;
        check({tag, "_count"}, 16'(obs_wr_q.size()), 16'(exp_wr_q.size()));
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            o = obs_wr_q.pop_front();
            check({tag, "_addr_data"}, o, e);
        end
        exp_wr_q.delete();
        obs_wr_q.delete();
    endtask

    initial begin
        logic [7:0] rx;
        RESET  = 1'b1;
        CS     = 1'b1;
        SCLK   = 1'b0;
        MOSI   = 1'b0;
        X_DATA = 8'h00;
        Y_DATA = 8'h00;
        Z_DATA = 8'h00;
        wait_clk(4);

        // Reset state
        check("rst_miso",   {15'd0, MISO},       16'd0);
        check("rst_busy",   {15'd0, BUSY},       16'd0);
        check("rst_strobe", {15'd0, WR_STROBE},  16'd0);
        check("rst_wraddr", {8'd0, WR_ADDR},     16'd0);
        check("rst_wrdata", {8'd0, WR_DATA},     16'd0);
        check("rst_meas",   {15'd0, MEASURE_EN}, 16'd0);
        RESET = 1'b0;
        wait_clk(4);

        // BUSY follows synchronized CS
        CS = 1'b0;
        wait_clk(4);
        check("busy_low_cs", {15'd0, BUSY}, 16'd1);
        CS = 1'b1;
        wait_clk(4);
        check("busy_high_cs", {15'd0, BUSY}, 16'd0);

        // Device id
        exp_rd_q.push_back(8'hAD);
        spi_read("devid", 8'h00, 1);

        // Write POWER_CTL, then read it back
        exp_wr_q.push_back({8'h2D, 8'h0A});
        spi_write(8'h2D, 16'h0A00, 1);
        check_writes("wr_2d");
        check("meas_en", {15'd0, MEASURE_EN}, 16'd1);
        exp_rd_q.push_back(8'h0A);
        spi_read("rd_2d", 8'h2D, 1);

        // Snapshot coherence: X changes after the address byte
        X_DATA = 8'h5A;
        exp_rd_q.push_back(8'h5A);
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h09, 8, rx);
        X_DATA = 8'h33;
        spi_bits(8'h00, 8, rx);
        check("snap_x", {8'h00, rx}, {8'h00, exp_rd_q.pop_front()});
        cs_end();

        // Three-byte burst from X
        X_DATA = 8'h11;
        Y_DATA = 8'h22;
        Z_DATA = 8'h33;
`ifdef SPI_ACCEL_TARGET_AUTOINC_EN
        exp_rd_q.push_back(8'h11);
        exp_rd_q.push_back(8'h22);
        exp_rd_q.push_back(8'h33);
`else
        exp_rd_q.push_back(8'h11);
        exp_rd_q.push_back(8'h11);
        exp_rd_q.push_back(8'h11);
`endif
        spi_read("burst_x", 8'h09, 3);

        // Two-byte burst write into the setup bank
`ifdef SPI_ACCEL_TARGET_AUTOINC_EN
        exp_wr_q.push_back({8'h21, 8'h12});
        exp_wr_q.push_back({8'h22, 8'h34});
        exp_rd_q.push_back(8'h12);
        exp_rd_q.push_back(8'h34);
`else
        exp_wr_q.push_back({8'h21, 8'h12});
        exp_wr_q.push_back({8'h21, 8'h34});
        exp_rd_q.push_back(8'h34);
        exp_rd_q.push_back(8'h34);
`endif
        spi_write(8'h21, 16'h1234, 2);
        check_writes("burst_wr");
        spi_read("burst_rd", 8'h21, 2);

        // Address 0xFF: unmapped, and wraps to DEVID when walking
`ifdef SPI_ACCEL_TARGET_AUTOINC_EN
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'hAD);
`else
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h00);
`endif
        spi_read("wrap_ff", 8'hFF, 2);

        // Partial write byte is dropped
        cs_begin();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'hFF, 4, rx);
        cs_end();
        check_writes("partial_wr");
        exp_rd_q.push_back(8'h00);
        spi_read("partial_rd", 8'h20, 1);

        // Unknown instruction: MISO stays 0, no strobes
        cs_begin();
        spi_bits(8'h0D, 8, rx);
        check("ign_miso0", {8'h00, rx}, 16'h0000);
        spi_bits(8'hFF, 8, rx);
        check("ign_miso1", {8'h00, rx}, 16'h0000);
        spi_bits(8'hFF, 8, rx);
        check("ign_miso2", {8'h00, rx}, 16'h0000);
        cs_end();
        check_writes("ignore");

        // Write outside the bank still strobes, but nothing is stored
        exp_wr_q.push_back({8'h05, 8'h77});
        spi_write(8'h05, 16'h7700, 1);
        check_writes("wr_05");
        exp_rd_q.push_back(8'h00);
        spi_read("rd_05", 8'h05, 1);

        // Reset in the middle of a read data byte
        X_DATA = 8'hFF;
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h09, 8, rx);
        spi_bits(8'h00, 5, rx);
        RESET = 1'b1;
        wait_clk(3);
        check("mid_rst_miso",   {15'd0, MISO},       16'd0);
        check("mid_rst_busy",   {15'd0, BUSY},       16'd0);
        check("mid_rst_wraddr", {8'd0, WR_ADDR},     16'd0);
        check("mid_rst_meas",   {15'd0, MEASURE_EN}, 16'd0);
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        wait_clk(2);
        RESET = 1'b0;
        wait_clk(2 * H);
        exp_rd_q.push_back(8'h00);
        spi_read("post_rst_2d", 8'h2D, 1);
        exp_rd_q.push_back(8'hAD);
        spi_read("post_rst_devid", 8'h00, 1);
        check_writes("post_rst");

        check("rd_queue_empty", 16'(exp_rd_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
